// File: rtl/mmu_pkg.sv
// rtl/mmu_pkg.sv - shared opcodes, MMU latency and sequencer state encoding
package mmu_pkg;

    localparam logic [7:0] OP_NOP      = 8'h00;
    localparam logic [7:0] OP_FP16_MAC = 8'h03;
    localparam logic [7:0] OP_INT8_DP  = 8'h04;

    // Cycles from launching operands to the MMU until its result is consumed
    localparam int MMU_LAT = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } seq_state_t;

    function automatic logic is_legal_op(input logic [7:0] op);
        return (op == OP_FP16_MAC) || (op == OP_INT8_DP);
    endfunction

endpackage

// File: rtl/mmu_dot_sequencer.sv
// rtl/mmu_dot_sequencer.sv - streams operand pairs into the MMU and accumulates its results
module mmu_dot_sequencer
    import mmu_pkg::*;
#(
    parameter int LEN_W = 8,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_opcode,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [31:0]      op_a,
    input  logic [31:0]      op_b,
    output logic [7:0]       mmu_opcode,
    output logic [31:0]      mmu_a,
    output logic [31:0]      mmu_b,
    input  logic [31:0]      mmu_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic             res_ovf,
    output logic             res_err
);

    seq_state_t          r_state;
    seq_state_t          w_next;
    logic                r_rst_done;
    logic [7:0]          r_opcode;
    logic [LEN_W-1:0]    r_rem;
    logic [MMU_LAT-1:0]  r_tag;
    logic [ACC_W-1:0]    r_acc;
    logic                r_ovf;
    logic                r_err;

    logic                w_cmd_fire;
    logic                w_issue;
    logic                w_last_issue;
    logic signed [ACC_W-1:0] w_ext;
    logic [ACC_W-1:0]    w_sum;
    logic                w_add_ovf;

    assign cmd_ready    = (r_state == ST_IDLE) && r_rst_done;
    assign op_ready     = (r_state == ST_STREAM) && (r_rem != '0);
    assign w_cmd_fire   = cmd_valid && cmd_ready;
    assign w_issue      = op_valid && op_ready;
    assign w_last_issue = w_issue && (r_rem == LEN_W'(1));

    assign res_valid = (r_state == ST_DONE);
    assign res_data  = r_acc;
    assign res_ovf   = r_ovf;
    assign res_err   = r_err;

    // The MMU result is a signed 32-bit partial sum; widen before adding
    assign w_ext     = ACC_W'($signed(mmu_result));
    assign w_sum     = r_acc + w_ext;
    assign w_add_ovf = (r_acc[ACC_W-1] == w_ext[ACC_W-1]) && (w_sum[ACC_W-1] != r_acc[ACC_W-1]);

    // State register; cmd_ready is held off until the first edge after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_rst_done <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_rst_done <= 1'b1;
        end
    end

    // Next-state decode: empty or illegal jobs skip straight to DONE
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd_fire) begin
                    if ((cmd_len == '0) || !is_legal_op(cmd_opcode)) w_next = ST_DONE;
                    else                                             w_next = ST_STREAM;
                end
            end
            ST_STREAM: if (w_last_issue)     w_next = ST_DRAIN;
            ST_DRAIN:  if (r_tag == '0)      w_next = ST_DONE;
            ST_DONE:   if (res_ready)        w_next = ST_IDLE;
            default:                         w_next = ST_IDLE;
        endcase
    end

    // Job bookkeeping: latched opcode and words still to issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opcode <= OP_NOP;
            r_rem    <= '0;
        end else if (w_cmd_fire) begin
            r_opcode <= cmd_opcode;
            r_rem    <= cmd_len;
        end else if (w_issue) begin
            r_rem    <= r_rem - LEN_W'(1);
        end
    end

    // MMU launch registers; any cycle without an issue drives a NOP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mmu_opcode <= OP_NOP;
            mmu_a      <= '0;
            mmu_b      <= '0;
        end else if (w_issue) begin
            mmu_opcode <= r_opcode;
            mmu_a      <= op_a;
            mmu_b      <= op_b;
        end else begin
            mmu_opcode <= OP_NOP;
        end
    end

    // Tag pipeline tracks which cycles carry a real MMU result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_tag <= '0;
        else        r_tag <= {r_tag[MMU_LAT-2:0], w_issue};
    end

    // Accumulator with sticky signed overflow, cleared at job start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
            r_err <= 1'b0;
        end else if (w_cmd_fire) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
            r_err <= !is_legal_op(cmd_opcode);
        end else if (r_tag[MMU_LAT-1]) begin
            r_acc <= w_sum;
            if (w_add_ovf) r_ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mmu_dot_sequencer.sv
// tb/tb_mmu_dot_sequencer.sv - directed bench with a behavioural MMU on the mmu_* port
module tb_mmu_dot_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_opcode = 8'h00;
    logic [7:0]  cmd_len = 8'h00;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [31:0] op_a = 32'h0;
    logic [31:0] op_b = 32'h0;
    logic [7:0]  mmu_opcode;
    logic [31:0] mmu_a;
    logic [31:0] mmu_b;
    logic [31:0] mmu_result;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic        res_ovf;
    logic        res_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mmu_dot_sequencer #(.LEN_W(8), .ACC_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode), .cmd_len(cmd_len),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .mmu_opcode(mmu_opcode), .mmu_a(mmu_a), .mmu_b(mmu_b), .mmu_result(mmu_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_ovf(res_ovf), .res_err(res_err)
    );

    // Behavioural MatrixMultiplyUnit: samples launched operands and registers the product sum
    function automatic logic [31:0] mmu_calc(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        int s;
        s = 0;
        if (op == 8'h04) begin
            for (int i = 0; i < 4; i++)
                s += int'($signed(a[8*i +: 8])) * int'($signed(b[8*i +: 8]));
        end else if (op == 8'h03) begin
            for (int i = 0; i < 2; i++)
                s += int'($signed(a[16*i +: 16])) * int'($signed(b[16*i +: 16]));
        end
        return 32'(s);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mmu_result <= 32'h0;
        else        mmu_result <= mmu_calc(mmu_opcode, mmu_a, mmu_b);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic run_job(input logic [7:0] op, input logic [7:0] len,
                           input logic [31:0] a, input logic [31:0] b,
                           input bit gaps, input int hold,
                           input logic [31:0] exp_data, input logic exp_ovf, input logic exp_err);
        int words;
        int issued;
        int cyc;
        int lat;
        int w;
        bit v;
        bit prev_gap;
        words = ((len != 0) && (op == 8'h03 || op == 8'h04)) ? int'(len) : 0;

        w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 10) begin
            w++;
            @(negedge clk);
        end
        chk("cmd_ready_idle", {31'h0, cmd_ready}, 32'h1);
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_len    = len;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (words == 0) chk("no_op_ready", {31'h0, op_ready}, 32'h0);

        issued   = 0;
        cyc      = 0;
        prev_gap = 1'b0;
        while (issued < words && cyc < 200) begin
            if (prev_gap) chk("gap_nop", {24'h0, mmu_opcode}, 32'h0);
            v        = gaps ? (cyc % 2 == 0) : 1'b1;
            op_valid = v;
            op_a     = v ? a : $urandom;
            op_b     = v ? b : $urandom;
            prev_gap = !v && op_ready;
            if (v && op_ready) issued++;
            cyc++;
            @(negedge clk);
        end
        op_valid = 1'b0;
        chk("words_issued", 32'(issued), 32'(words));
        if (words > 0) chk("drain_op_ready", {31'h0, op_ready}, 32'h0);

        lat = 0;
        while (!res_valid && lat < 20) begin
            lat++;
            @(negedge clk);
        end
        chk("res_valid", {31'h0, res_valid}, 32'h1);
        chk("latency", 32'(lat), (words > 0) ? 32'd3 : 32'd0);
        chk("res_data", res_data, exp_data);
        chk("res_ovf", {31'h0, res_ovf}, {31'h0, exp_ovf});
        chk("res_err", {31'h0, res_err}, {31'h0, exp_err});

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'h0, res_valid}, 32'h1);
            chk("hold_data", res_data, exp_data);
            chk("hold_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        end

        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("valid_cleared", {31'h0, res_valid}, 32'h0);
        chk("back_idle", {31'h0, cmd_ready}, 32'h1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        chk("rst_op_ready", {31'h0, op_ready}, 32'h0);
        chk("rst_res_valid", {31'h0, res_valid}, 32'h0);
        chk("rst_mmu_op", {24'h0, mmu_opcode}, 32'h0);
        chk("rst_res_data", res_data, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);

        run_job(8'h04, 8'd1, 32'h01020304, 32'h01010101, 1'b0, 0, 32'd10, 1'b0, 1'b0);
        run_job(8'h04, 8'd2, 32'hFFFFFFFF, 32'h02020202, 1'b0, 0, 32'hFFFFFFF0, 1'b0, 1'b0);
        run_job(8'h03, 8'd2, 32'h00020003, 32'h00040005, 1'b0, 0, 32'd46, 1'b0, 1'b0);
        run_job(8'h03, 8'd2, 32'h00020003, 32'h00040005, 1'b1, 0, 32'd46, 1'b0, 1'b0);
        run_job(8'h03, 8'd2, 32'h7FFF7FFF, 32'h7FFF7FFF, 1'b0, 0, 32'hFFFC0004, 1'b1, 1'b0);
        run_job(8'h04, 8'd0, 32'h01020304, 32'h01010101, 1'b0, 0, 32'd0, 1'b0, 1'b0);
        run_job(8'h07, 8'd4, 32'h01020304, 32'h01010101, 1'b0, 0, 32'd0, 1'b0, 1'b1);
        run_job(8'h04, 8'd3, 32'h01020304, 32'h01010101, 1'b0, 5, 32'd30, 1'b0, 1'b0);

        // Reset in the middle of a stream
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_opcode = 8'h04;
        cmd_len    = 8'd4;
        @(negedge clk);
        cmd_valid = 1'b0;
        op_valid  = 1'b1;
        op_a      = 32'h01020304;
        op_b      = 32'h01010101;
        repeat (2) @(negedge clk);
        rst_n    = 1'b0;
        op_valid = 1'b0;
        #1;
        chk("mid_rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        chk("mid_rst_op_ready", {31'h0, op_ready}, 32'h0);
        chk("mid_rst_res_valid", {31'h0, res_valid}, 32'h0);
        chk("mid_rst_mmu_op", {24'h0, mmu_opcode}, 32'h0);
        chk("mid_rst_mmu_a", mmu_a, 32'h0);
        chk("mid_rst_mmu_b", mmu_b, 32'h0);
        chk("mid_rst_res_data", res_data, 32'h0);
        chk("mid_rst_flags", {30'h0, res_ovf, res_err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_stale_valid", {31'h0, res_valid}, 32'h0);
        end
        run_job(8'h04, 8'd1, 32'h01020304, 32'h01010101, 1'b0, 0, 32'd10, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
